// File: rtl/cache_pkg.sv
// Shared types and constants for the L1/L2 cache slice:
// arbiter FSM states, the packed L1 block type and the requester count.
package cache_pkg;

  localparam int NUM_REQ           = 2;
  localparam int DEF_ADDR_WIDTH    = 11;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_L1_BLOCK_SIZE = 16;
  localparam int PERF_W            = 16;

  typedef logic [DEF_L1_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] l1_block_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } l2_op_t;

  // Saturating increment for the performance counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector: on a tie the requester that
// was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    // NOTE: every combinational output is assigned a default before the case,
    // so no path leaves it unassigned and no latch is inferred.
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L1-facing port of L2_cache between two L1 caches with
// round-robin grants. Define L2_ARB_PERF_EN to add saturating grant/conflict counters.
module l2_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int L1_BLOCK_SIZE = DEF_L1_BLOCK_SIZE
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
`ifdef L2_ARB_PERF_EN
  output logic [PERF_W-1:0]                                    perf_grant0,
  output logic [PERF_W-1:0]                                    perf_grant1,
  output logic [PERF_W-1:0]                                    perf_conflict,
`endif
  input  logic [NUM_REQ-1:0]                                   rq_read,
  input  logic [NUM_REQ-1:0]                                   rq_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                   rq_addr,
  input  logic [NUM_REQ-1:0][L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rq_data_in,
  output logic [NUM_REQ-1:0][L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rq_data_out,
  output logic [NUM_REQ-1:0]                                   rq_hit,
  output logic [NUM_REQ-1:0]                                   rq_ready,
  output logic [ADDR_WIDTH-1:0]                                l2_cache_addr,
  output logic                                                 l2_cache_read,
  output logic                                                 l2_cache_write,
  output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]             l2_cache_data_out,
  input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]             l2_cache_data_in,
  input  logic                                                 l2_cache_ready,
  input  logic                                                 l2_cache_hit
);

  typedef logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

  arb_state_t                state_q, state_d;
  logic                      last_q, last_d;
  logic                      gnt_q, gnt_d;
  l2_op_t                    op_q, op_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  blk_t                      wdata_q, wdata_d;
  logic [NUM_REQ-1:0][L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REQ-1:0]        hit_q, hit_d;

  logic [NUM_REQ-1:0]        req_active;
  logic                      pick_valid;
  logic                      pick_idx;

  assign req_active = rq_read | rq_write;

  rr_pick2 u_pick (
    .req       (req_active),
    .last      (last_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          // A request with both read and write set is a write-back.
          op_d    = rq_write[pick_idx] ? OP_WRITE : OP_READ;
          addr_d  = rq_addr[pick_idx];
          wdata_d = rq_data_in[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (l2_cache_ready) begin
          rdata_d[gnt_q] = l2_cache_data_in;
          hit_d[gnt_q]   = l2_cache_hit;
          state_d        = DONE;
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the block-wide data registers are reset as well, because the
  // returned-block outputs must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of its inputs.
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign l2_cache_read     = (state_q == ISSUE) && (op_q == OP_READ);
  assign l2_cache_write    = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign l2_cache_addr     = addr_q;
  assign l2_cache_data_out = wdata_q;
  assign rq_data_out       = rdata_q;
  assign rq_hit            = hit_q;

  always_comb begin
    rq_ready = '0;
    if (state_q == DONE) rq_ready[gnt_q] = 1'b1;
  end

`ifdef L2_ARB_PERF_EN
  logic              grant_fire;
  logic [PERF_W-1:0] grant0_q, grant1_q, conflict_q;

  assign grant_fire = (state_q == IDLE) && pick_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (grant_fire && !pick_idx) grant0_q <= sat_inc(grant0_q);
      if (grant_fire && pick_idx)  grant1_q <= sat_inc(grant1_q);
      if (grant_fire && (&req_active)) conflict_q <= sat_inc(conflict_q);
    end
  end

  assign perf_grant0   = grant0_q;
  assign perf_grant1   = grant1_q;
  assign perf_conflict = conflict_q;
`endif

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Two-requester arbiter that shares the single L1-facing port of `L2_cache` between two L1 caches (e.g. instruction-side and data-side `L1_cache` instances). Each requester presents block-granular read or write-back requests. The arbiter grants one at a time with round-robin priority, sequences the transaction onto the L2 port, and returns the L2 block data, hit flag and a one-cycle ready pulse to the granted requester. It sits between the L1 instances and `L2_cache`, replacing the direct L1→L2 wiring.

## Interface
- `ADDR_WIDTH`, 11, byte address width.
- `DATA_WIDTH`, 8, bits per byte lane.
- `L1_BLOCK_SIZE`, 16, bytes per L1 block; block buses are `[L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]`.
- `clk  in  1`  the single clock; everything is on the rising edge.
- `rst_n  in  1`  reset, asynchronous and active-low.
- `rq_read[i]  in  1`  block read request from requester i (i = 0,1); held until `rq_ready[i]`.
- `rq_write[i]  in  1`  block write-back request; held until `rq_ready[i]`.
- `rq_addr[i]  in  ADDR_WIDTH`  block address from requester i.
- `rq_data_in[i]  in  L1_BLOCK_SIZE*DATA_WIDTH`  write-back block.
- `rq_data_out[i]  out  L1_BLOCK_SIZE*DATA_WIDTH`  returned block, valid while `rq_ready[i]`=1.
- `rq_hit[i]  out  1`  L2 hit flag for the completed transaction, valid with `rq_ready[i]`.
- `rq_ready[i]  out  1`  one-cycle completion pulse.
- `l2_cache_addr  out  ADDR_WIDTH`, `l2_cache_read  out  1`, `l2_cache_write  out  1`, `l2_cache_data_out  out  L1_BLOCK_SIZE*DATA_WIDTH`: these drive `L2_cache`.
- `l2_cache_data_in  in  L1_BLOCK_SIZE*DATA_WIDTH`, `l2_cache_ready  in  1`, `l2_cache_hit  in  1`: these come from `L2_cache`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset enters IDLE.
- IDLE: a requester is active when `rq_read|rq_write` is set.
  - If no requester is active, stay in IDLE.
  - If one is active, grant it.
  - If both are active, grant the one not equal to `last_grant`.
  - On a grant, latch the grant index, addr, op and data, then go to ISSUE.
- Op rule: if `rq_read` and `rq_write` are both high, the op is a write.
- ISSUE: drive the latched addr and data. Assert exactly one of `l2_cache_read` / `l2_cache_write` for one cycle. Go to WAIT.
- WAIT: `l2_cache_read` and `l2_cache_write` are low; addr and data stay stable. When `l2_cache_ready`=1, register `l2_cache_data_in` into `rq_data_out[g]` and `l2_cache_hit` into `rq_hit[g]`, then go to DONE.
- DONE: `rq_ready[g]`=1 for this cycle only. Set `last_grant`=g and go to IDLE.
- Requester rule: the requester drops its request on the edge that samples `rq_ready`. The arbiter samples no requests in DONE.
- `rq_data_out` and `rq_hit` hold their last value until the next completion for that requester.
- The non-granted requester's outputs never change during another requester's transaction.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=1 (so requester 0 wins the first tie).
  - All `rq_ready`, `rq_hit` and `l2_cache_read`/`l2_cache_write` = 0.
  - `l2_cache_addr`, `l2_cache_data_out` and all `rq_data_out` = 0.
- Latency: request sampled in IDLE at edge k, then L2 strobe during cycle k+1, then WAIT from k+2.
- If `l2_cache_ready` is sampled at edge m, `rq_ready` is high during cycle m+1. Minimum request-to-ready time is 4 cycles.
- Back-to-back: the earliest next grant is sampled on the edge after DONE. Alternation under continuous contention is strict 0,1,0,1.
- `l2_cache_ready` outside WAIT is ignored.
- Asynchronous reset mid-transaction aborts it. No `rq_ready` is issued, and the L2 strobe drops immediately.

## Configuration
- `L2_ARB_PERF_EN` defined: adds outputs `perf_grant0`, `perf_grant1` and `perf_conflict`, each 16 bits, saturating at 0xFFFF, reset to 0.
  - A grant counter increments in the cycle its requester enters ISSUE.
  - `perf_conflict` increments on each IDLE grant where both requesters were active.
- Not defined: these ports and counters are absent. Arbitration behaviour is identical either way.

## Structure
- Shared package `cache_pkg` holds:
  - the `arb_state_t` enum (IDLE/ISSUE/WAIT/DONE);
  - the `l1_block_t` typedef for the packed block;
  - the `NUM_REQ`=2 constant.
- One sub-module, `rr_pick2`: combinational 2-way round-robin selector with inputs `req[1:0]` and `last` and outputs `gnt_valid` and `gnt_idx`.

## Test plan
- Single read: req0 read at 0x040, L2 model returns ready after 3 cycles with data 0x0F..00 and hit=1 → exactly one `l2_cache_read` pulse with addr 0x040; `rq_ready[0]` pulses once with that data and `rq_hit[0]`=1; `rq_ready[1]` stays 0.
- Simultaneous reads from reset: req0 at 0x010, req1 at 0x020 → requester 0 served first, then requester 1; L2 addresses are 0x010 then 0x020.
- Sustained contention, 6 requests each → grant order 0,1,0,1,...; with `L2_ARB_PERF_EN`, `perf_grant0`=6, `perf_grant1`=6, `perf_conflict`≥10.
- Write-back: req1 write at 0x100 with data all 0xA5 → one `l2_cache_write` pulse, `l2_cache_data_out`=all 0xA5, `rq_ready[1]` pulse.
- Read and write both set on req0 → treated as a write; `l2_cache_read` is never asserted.
- `rst_n` asserted low in WAIT → all outputs 0 immediately; no `rq_ready`; after release, the next request is served normally.
